mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter that shares the processor's single memory port between instruction fetch (requester 0) and data/stack access (requester 1: lw, sw, push, pop). It sits between the control unit's memory-request logic and the memory model. It serialises requests with round-robin priority and drives the existing MEM_ADDR / MEM_READ / MEM_WRITE / MEM_DATA (inout) interface. Each access is held for a fixed memory latency, and completion is returned with a one-cycle DONE pulse.

## Interface
Parameters:
- ADDR_W, 26, memory address width
- DATA_W, 32, memory data width
- MEM_LAT, 2, cycles MEM_READ/MEM_WRITE are held per access (legal range 1..15)

Ports:
- CLK  in  1  clock; all state changes on the rising edge
- RST  in  1  reset; one clock, synchronous, active-high
- REQ0, REQ1  in  1  access request from requester 0 / 1
- WE0, WE1  in  1  1 = write, 0 = read
- ADDR0, ADDR1  in  ADDR_W  access address
- WDATA0, WDATA1  in  DATA_W  write data
- GNT0, GNT1  out  1  requester owns the port (ACCESS and RESP states)
- DONE0, DONE1  out  1  one-cycle completion pulse
- RDATA  out  DATA_W  read data, valid while DONEx=1 and held until the next read completes
- MEM_ADDR  out  ADDR_W  memory address
- MEM_READ, MEM_WRITE  out  1  memory strobes; 00 = no-op
- MEM_DATA  inout  DATA_W  driven with the granted WDATA only while MEM_WRITE=1, otherwise high-Z

## Operation
- States: IDLE, ACCESS, RESP. State encodings are 2-bit constants.
- IDLE:
  - If no REQ is high, stay in IDLE.
  - If exactly one REQ is high, grant that requester.
  - If both are high, grant the requester not equal to the LAST register.
  - On a grant: latch the owner, set LAST = owner, load CNT = MEM_LAT-1, and go to ACCESS.
- ACCESS:
  - Output MEM_ADDR = ADDRx of the owner.
  - Assert MEM_READ = ~WEx and MEM_WRITE = WEx.
  - If CNT != 0, decrement CNT.
  - If CNT == 0 on a read, capture MEM_DATA into RDATA, then go to RESP.
  - If CNT == 0 on a write, go to RESP.
- RESP:
  - Strobes return to 00. MEM_ADDR holds its value.
  - DONEx = 1 for this cycle only. GNTx stays 1.
  - Next state is always IDLE.
- The requester holds REQ, WE, ADDR and WDATA stable from assertion until it sees DONE. It deasserts REQ no later than the cycle after DONE. A REQ still high in IDLE is treated as a new request.
- REQ dropped during ACCESS is ignored; the access completes.
- The owner's inputs are sampled combinationally during ACCESS. Only the owner latch and RDATA are registered.
- The non-owner's REQ is ignored until the arbiter returns to IDLE. No request is lost while REQ stays high.

## Timing
- Reset values: state IDLE, CNT 0, LAST 1 (requester 0 wins the first tie), GNT0/1 0, DONE0/1 0, RDATA 0, MEM_ADDR 0, MEM_READ/MEM_WRITE 0, MEM_DATA Z.
- RST asserted mid-access aborts the access on the next edge. No DONE is issued and RDATA is not updated.
- Transaction sequence, with REQ sampled in IDLE at edge k:
  - GNT and strobes are high for cycles k+1 through k+MEM_LAT.
  - DONE is high in cycle k+MEM_LAT+1.
  - IDLE in cycle k+MEM_LAT+2.
- The minimum spacing between grants is MEM_LAT+2 cycles. GNT0 and GNT1 are never both high.
- With MEM_LAT=1: a single ACCESS cycle, and read data is captured at the end of that cycle.
- Under continuous dual requests, grants strictly alternate 0,1,0,1.

## Structure
- Shared definition header (alongside the existing project definitions) holds:
  - width constants,
  - state encodings ARB_IDLE = 2'd0, ARB_ACCESS = 2'd1, ARB_RESP = 2'd2,
  - the MEM_LAT default.
- One sub-module: arb_rr_pick. It is purely combinational, with inputs REQ0, REQ1, LAST and outputs VALID and WINNER. The FSM, counter and tristate live in mem_port_arbiter.

## Test plan
- Reset defaults: RST high for 2 cycles → all outputs at their reset values and MEM_DATA = Z.
- Single read: REQ0 with ADDR0=0x1000, WE0=0; memory returns 0x20010005 → MEM_READ high exactly 2 cycles, DONE0 in cycle 3, RDATA=0x20010005.
- Single write: REQ1 with WE1=1, ADDR1=0x03FF, WDATA1=0xDEADBEEF → MEM_WRITE high 2 cycles, MEM_DATA=0xDEADBEEF only during those cycles, DONE1 pulses once, RDATA unchanged.
- Tie and alternation: REQ0=REQ1=1 held from reset → grant order 0,1,0,1 and grants spaced 4 cycles apart (MEM_LAT=2).
- Mid-access reset: RST asserted in the second ACCESS cycle → next cycle is IDLE, strobes 00, no DONE, LAST=1.
- MEM_LAT=1 build: back-to-back REQ0 reads → DONE every 3 cycles and correct RDATA each time.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: widths, latency default and FSM encodings.
package mem_port_arbiter_pkg;

    localparam int ARB_ADDR_W  = 26;
    localparam int ARB_DATA_W  = 32;
    localparam int ARB_MEM_LAT = 2;
    // Wide enough for MEM_LAT-1 over the legal latency range 1..15.
    localparam int ARB_CNT_W   = 4;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to the side that did not win last.
module arb_rr_pick (
    input  logic REQ0,
    input  logic REQ1,
    input  logic LAST,
    output logic VALID,
    output logic WINNER
);

    assign VALID  = REQ0 | REQ1;
    assign WINNER = (REQ0 & REQ1) ? ~LAST : REQ1;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch (0) and data/stack access (1),
// holding each access for MEM_LAT cycles and returning a one-cycle DONE pulse.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ARB_ADDR_W,
    parameter int DATA_W  = ARB_DATA_W,
    parameter int MEM_LAT = ARB_MEM_LAT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ0,
    input  logic              REQ1,
    input  logic              WE0,
    input  logic              WE1,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic [ADDR_W-1:0] ADDR1,
    input  logic [DATA_W-1:0] WDATA0,
    input  logic [DATA_W-1:0] WDATA1,
    output logic              GNT0,
    output logic              GNT1,
    output logic              DONE0,
    output logic              DONE1,
    output logic [DATA_W-1:0] RDATA,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    inout  wire  [DATA_W-1:0] MEM_DATA,
    output logic [1:0]        DBG_STATE
);

    // Handshake: a requester raises REQx with WEx/ADDRx/WDATAx stable and keeps them until
    // it sees DONEx; it drops REQx by the cycle after DONEx, and REQx high in IDLE is a new request.

    arb_state_t           state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 last_q, last_d;
    logic [ARB_CNT_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]    rdata_q;
    logic                 capture;
    logic                 pick_valid, pick_winner;
    logic                 in_access, owned;
    logic                 own_we;
    logic [ADDR_W-1:0]    own_addr;
    logic [DATA_W-1:0]    own_wdata;

    arb_rr_pick u_pick (
        .REQ0   (REQ0),
        .REQ1   (REQ1),
        .LAST   (last_q),
        .VALID  (pick_valid),
        .WINNER (pick_winner)
    );

    // Owner inputs are used live; the requester keeps them stable until DONE.
    assign own_we    = owner_q ? WE1    : WE0;
    assign own_addr  = owner_q ? ADDR1  : ADDR0;
    assign own_wdata = owner_q ? WDATA1 : WDATA0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ARB_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                rdata_q <= MEM_DATA;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_winner;
                    last_d  = pick_winner;
                    cnt_d   = ARB_CNT_W'(MEM_LAT - 1);
                    state_d = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - ARB_CNT_W'(1);
                end else begin
                    capture = ~own_we;
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    assign in_access = (state_q == ARB_ACCESS);
    assign owned     = in_access | (state_q == ARB_RESP);

    assign GNT0      = owned & ~owner_q;
    assign GNT1      = owned &  owner_q;
    assign DONE0     = (state_q == ARB_RESP) & ~owner_q;
    assign DONE1     = (state_q == ARB_RESP) &  owner_q;
    assign MEM_READ  = in_access & ~own_we;
    assign MEM_WRITE = in_access &  own_we;
    assign MEM_ADDR  = owned ? own_addr : '0;
    assign MEM_DATA  = MEM_WRITE ? own_wdata : 'z;
    assign RDATA     = rdata_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter (MEM_LAT=2 main instance, MEM_LAT=1 side instance).
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int LAT   = 2;
    localparam int AW    = 26;
    localparam int DW    = 32;
    localparam int EXP_W = 1 + AW + DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, done0, done1, mem_read, mem_write;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    wire  [DW-1:0] mem_data;
    logic [1:0]    dbg_state;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) u_dut (
        .CLK(clk), .RST(rst), .REQ0(req0), .REQ1(req1), .WE0(we0), .WE1(we1),
        .ADDR0(addr0), .ADDR1(addr1), .WDATA0(wdata0), .WDATA1(wdata1),
        .GNT0(gnt0), .GNT1(gnt1), .DONE0(done0), .DONE1(done1), .RDATA(rdata),
        .MEM_ADDR(mem_addr), .MEM_READ(mem_read), .MEM_WRITE(mem_write),
        .MEM_DATA(mem_data), .DBG_STATE(dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] init_val(input int i);
        return 32'h20010005 ^ (i * 32'h9E3779B1);
    endfunction

    // Requester 0 uses addresses with bit 7 clear, requester 1 with bit 7 set, so the
    // reference memory of each requester evolves independently of grant order.
    function automatic logic [AW-1:0] rand_addr(input logic r);
        logic [AW-1:0] a;
        a    = AW'($urandom);
        a[7] = r;
        return a;
    endfunction

    // ---------------- memory model on the bus ----------------
    logic [DW-1:0] mem_arr [256];
    bit            mem_inited = 1'b0;

    always @(negedge clk) begin
        if (!mem_inited) begin
            for (int i = 0; i < 256; i++) mem_arr[i] = init_val(i);
            mem_inited = 1'b1;
        end else if (mem_write) begin
            mem_arr[mem_addr[7:0]] = mem_data;
        end
    end
    assign mem_data = mem_read ? mem_arr[mem_addr[7:0]] : 'z;

    // ---------------- reference model and expected queues ----------------
    logic [DW-1:0]    ref_mem [256];
    logic [EXP_W-1:0] exp_q0[$];
    logic [EXP_W-1:0] exp_q1[$];
    bit               mon_en = 1'b0;

    task automatic do_txn(input logic r, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata);
        logic [DW-1:0] d;
        bit            got;
        d = we ? wdata : ref_mem[addr[7:0]];
        if (we) ref_mem[addr[7:0]] = wdata;
        if (r) exp_q1.push_back({we, addr, d});
        else   exp_q0.push_back({we, addr, d});
        @(posedge clk);
        #1;
        if (r) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; end
        else   begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; end
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (r ? done1 : done0) got = 1'b1;
        end
        check(r ? "done1_timeout" : "done0_timeout", 64'(got), 64'd1);
        if (r) req1 = 1'b0;
        else   req0 = 1'b0;
    endtask

    // ---------------- monitor ----------------
    int               cyc = 0;
    int               last_start = -100;
    int               mon_phase = 0;
    int               sz;
    bit               mon_active = 1'b0;
    logic             mon_owner = 1'b0;
    logic             mon_last = 1'b1;
    logic             req_prev0 = 1'b0, req_prev1 = 1'b0;
    logic             w, m_we;
    logic [AW-1:0]    m_addr;
    logic [DW-1:0]    m_data;
    logic [DW-1:0]    model_rdata = '0;
    logic [EXP_W-1:0] mon_cur = '0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            mon_active  = 1'b0;
            mon_last    = 1'b1;
            model_rdata = '0;
            last_start  = -100;
        end else if (mon_en) begin
            check("gnt_exclusive", 64'(gnt0 & gnt1), 64'd0);
            if (!mon_active && (gnt0 | gnt1)) begin
                if (!(req_prev0 | req_prev1)) begin
                    check("gnt_without_req", 64'({gnt0, gnt1}), 64'd0);
                end else begin
                    w = (req_prev0 & req_prev1) ? ~mon_last : req_prev1;
                    check("gnt_winner", 64'(gnt1), 64'(w));
                    check("gnt_spacing_ok", 64'(cyc - last_start >= LAT + 2), 64'd1);
                    last_start = cyc;
                    mon_last   = w;
                    mon_owner  = w;
                    sz = w ? exp_q1.size() : exp_q0.size();
                    check("exp_q_depth", 64'(sz), 64'd1);
                    if (sz > 0) begin
                        mon_cur    = w ? exp_q1[0] : exp_q0[0];
                        mon_active = 1'b1;
                        mon_phase  = 0;
                    end
                end
            end else if (!mon_active) begin
                check("idle_quiet", 64'({done0, done1, mem_read, mem_write}), 64'd0);
                check("idle_mem_data_z", 64'(mem_data === 'z), 64'd1);
            end
            if (mon_active) begin
                m_we   = mon_cur[EXP_W-1];
                m_addr = mon_cur[DW +: AW];
                m_data = mon_cur[DW-1:0];
                if (mon_phase < LAT) begin
                    check("access_gnt", 64'({gnt0, gnt1}), mon_owner ? 64'd1 : 64'd2);
                    check("access_strobes", 64'({mem_read, mem_write}), 64'({~m_we, m_we}));
                    check("access_addr", 64'(mem_addr), 64'(m_addr));
                    check("access_done_low", 64'({done0, done1}), 64'd0);
                    if (m_we) check("write_data", 64'(mem_data), 64'(m_data));
                end else begin
                    check("resp_done", 64'({done0, done1}), mon_owner ? 64'd1 : 64'd2);
                    check("resp_gnt", 64'({gnt0, gnt1}), mon_owner ? 64'd1 : 64'd2);
                    check("resp_strobes", 64'({mem_read, mem_write}), 64'd0);
                    check("resp_mem_data_z", 64'(mem_data === 'z), 64'd1);
                    if (!m_we) model_rdata = m_data;
                    check("resp_rdata", 64'(rdata), 64'(model_rdata));
                    if (mon_owner) void'(exp_q1.pop_front());
                    else           void'(exp_q0.pop_front());
                    mon_active = 1'b0;
                end
                mon_phase++;
            end
        end
        req_prev0 = req0;
        req_prev1 = req1;
    end

    // ---------------- MEM_LAT=1 instance ----------------
    logic          l1_rst = 1'b1, l1_req0 = 1'b0;
    logic [AW-1:0] l1_addr0 = '0;
    logic          l1_gnt0, l1_gnt1, l1_done0, l1_done1, l1_mem_read, l1_mem_write;
    logic [DW-1:0] l1_rdata;
    logic [AW-1:0] l1_mem_addr;
    wire  [DW-1:0] l1_mem_data;
    logic [1:0]    l1_dbg_state;
    bit            l1_finished = 1'b0;

    function automatic logic [DW-1:0] l1_f(input logic [AW-1:0] a);
        return 32'h20010005 ^ {a[15:0], a[15:0]};
    endfunction

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut_l1 (
        .CLK(clk), .RST(l1_rst), .REQ0(l1_req0), .REQ1(1'b0), .WE0(1'b0), .WE1(1'b0),
        .ADDR0(l1_addr0), .ADDR1('0), .WDATA0('0), .WDATA1('0),
        .GNT0(l1_gnt0), .GNT1(l1_gnt1), .DONE0(l1_done0), .DONE1(l1_done1), .RDATA(l1_rdata),
        .MEM_ADDR(l1_mem_addr), .MEM_READ(l1_mem_read), .MEM_WRITE(l1_mem_write),
        .MEM_DATA(l1_mem_data), .DBG_STATE(l1_dbg_state)
    );
    assign l1_mem_data = l1_mem_read ? l1_f(l1_mem_addr) : 'z;

    initial begin
        int  t, prev, reads;
        bit  got;
        t = 0;
        prev = 0;
        repeat (2) @(posedge clk);
        #1;
        l1_rst   = 1'b0;
        l1_addr0 = rand_addr(1'b0);
        l1_req0  = 1'b1;
        for (int n = 0; n < 6; n++) begin
            got   = 1'b0;
            reads = 0;
            for (int i = 0; i < 12 && !got; i++) begin
                @(negedge clk);
                t++;
                if (l1_mem_read) reads++;
                if (l1_done0) got = 1'b1;
            end
            check("l1_done_seen", 64'(got), 64'd1);
            if (got) begin
                check("l1_rdata", 64'(l1_rdata), 64'(l1_f(l1_addr0)));
                check("l1_read_cycles", 64'(reads), 64'd1);
                check("l1_resp_outputs", 64'({l1_gnt0, l1_gnt1, l1_mem_write, l1_done1}), 64'd8);
                check("l1_resp_state", 64'(l1_dbg_state), 64'(ARB_RESP));
                if (n > 0) check("l1_done_period", 64'(t - prev), 64'd3);
                prev     = t;
                l1_addr0 = rand_addr(1'b0);
            end
        end
        l1_req0     = 1'b0;
        l1_finished = 1'b1;
    end

    // ---------------- main stimulus ----------------
    initial begin
        bit seen;
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", 64'({gnt0, gnt1}), 64'd0);
        check("rst_done", 64'({done0, done1}), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_strobes", 64'({mem_read, mem_write}), 64'd0);
        check("rst_mem_data_z", 64'(mem_data === 'z), 64'd1);
        check("rst_state", 64'(dbg_state), 64'(ARB_IDLE));
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        do_txn(1'b0, 1'b0, 26'h1000, 32'h0);
        do_txn(1'b1, 1'b1, 26'h03FF, 32'hDEADBEEF);

        // Continuous dual requests: grants must alternate.
        fork
            repeat (6) do_txn(1'b0, 1'($urandom), rand_addr(1'b0), $urandom);
            repeat (6) do_txn(1'b1, 1'($urandom), rand_addr(1'b1), $urandom);
        join

        fork
            repeat (20) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                do_txn(1'b0, 1'($urandom), rand_addr(1'b0), $urandom);
            end
            repeat (20) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                do_txn(1'b1, 1'($urandom), rand_addr(1'b1), $urandom);
            end
        join

        // Reset in the second ACCESS cycle of a read aborts it without DONE.
        repeat (2) @(posedge clk);
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        req0 = 1'b1; we0 = 1'b0; addr0 = rand_addr(1'b0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (gnt0) seen = 1'b1;
        end
        check("abort_gnt_seen", 64'(seen), 64'd1);
        @(posedge clk);
        #1;
        rst  = 1'b1;
        req0 = 1'b0;
        @(negedge clk);
        check("abort_second_access", 64'({mem_read, gnt0}), 64'd3);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_state_idle", 64'(dbg_state), 64'(ARB_IDLE));
        check("abort_strobes", 64'({mem_read, mem_write}), 64'd0);
        check("abort_no_done", 64'({done0, done1, gnt0, gnt1}), 64'd0);
        check("abort_rdata", 64'(rdata), 64'd0);
        mon_en = 1'b1;

        // After reset LAST=1, so requester 0 must win this tie.
        fork
            do_txn(1'b0, 1'b0, rand_addr(1'b0), 32'h0);
            do_txn(1'b1, 1'b0, rand_addr(1'b1), 32'h0);
        join

        for (int i = 0; i < 500 && !l1_finished; i++) @(posedge clk);
        check("l1_finished", 64'(l1_finished), 64'd1);
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, vectors %0d miscompares %0d",
                 vectors, miscompares);
        $fatal(1, "watchdog");
    end

endmodule
